// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC and queues {PC, instruction} pairs for decode.
// Optional taken-redirect counter is enabled by defining FETCH_REDIRECT_COUNT_EN.
module fetch_queue #(
  parameter int                 DEPTH    = 32'd4,
  parameter int                 ADDR_W   = 32'd10,
  parameter int                 INSTR_W  = 32'd16,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                      Clock,
  input  logic                      Reset,
  output logic [ADDR_W-1:0]         oAddressPC,
  input  logic [INSTR_W-1:0]        iInstruction,
  input  logic                      iBranchTaken,
  input  logic [ADDR_W-1:0]         iBranchTarget,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [INSTR_W-1:0]        oInstruction,
  output logic [ADDR_W-1:0]         oPC,
  output logic [$clog2(DEPTH):0]    oCount
`ifdef FETCH_REDIRECT_COUNT_EN
  ,
  output logic [15:0]               oRedirectCount
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]  fetchPc_r;
  logic [ADDR_W-1:0]  pcMem_r    [DEPTH];
  logic [INSTR_W-1:0] instrMem_r [DEPTH];
  logic [PTR_W-1:0]   wrPtr_r;
  logic [PTR_W-1:0]   rdPtr_r;
  logic [CNT_W-1:0]   count_r;

  logic valid_s;
  logic full_s;
  logic pop_s;
  logic push_s;

  // Handshake decode; a full queue still accepts a push when the head leaves this cycle.
  always_comb begin
    valid_s = (count_r != {CNT_W{1'b0}});
    full_s  = (count_r == CNT_FULL);
    pop_s   = valid_s & iReady;
    push_s  = ~iBranchTaken & (~full_s | pop_s);
  end

  // Fetch PC, storage, pointers and occupancy; Reset beats redirect beats normal flow.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetchPc_r <= RESET_PC;
      wrPtr_r   <= {PTR_W{1'b0}};
      rdPtr_r   <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pcMem_r[i]    <= {ADDR_W{1'b0}};
        instrMem_r[i] <= {INSTR_W{1'b0}};
      end
    end else if (iBranchTaken) begin
      // A coincident pop is consumed by the decoder; everything left is wrong-path.
      fetchPc_r <= iBranchTarget;
      wrPtr_r   <= {PTR_W{1'b0}};
      rdPtr_r   <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pcMem_r[wrPtr_r]    <= fetchPc_r;
        instrMem_r[wrPtr_r] <= iInstruction;
        wrPtr_r             <= wrPtr_r + PTR_ONE;
        fetchPc_r           <= fetchPc_r + PC_ONE;
      end else begin
        fetchPc_r <= fetchPc_r;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end else begin
        rdPtr_r <= rdPtr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0] redirectCount_r;

  // Saturating count of taken redirects.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      redirectCount_r <= 16'h0000;
    end else if (iBranchTaken && (redirectCount_r != 16'hFFFF)) begin
      redirectCount_r <= redirectCount_r + 16'h0001;
    end else begin
      redirectCount_r <= redirectCount_r;
    end
  end

  assign oRedirectCount = redirectCount_r;
`else
  // No redirect statistics in this build.
`endif

  assign oAddressPC   = fetchPc_r;
  assign oValid       = valid_s;
  assign oCount       = count_r;
  assign oPC          = pcMem_r[rdPtr_r];
  assign oInstruction = instrMem_r[rdPtr_r];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 10'h000;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic [ADDR_W-1:0]  oAddressPC;
  logic [INSTR_W-1:0] iInstruction;
  logic               iBranchTaken = 1'b0;
  logic [ADDR_W-1:0]  iBranchTarget = 10'h000;
  logic               oValid;
  logic               iReady = 1'b0;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic [2:0]         oCount;
`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0]        oRedirectCount;
`endif

  always #5 Clock = ~Clock;

  function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return {a[5:0] ^ 6'h2A, a};
  endfunction

  assign iInstruction = memWord(oAddressPC);

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .Clock(Clock), .Reset(Reset), .oAddressPC(oAddressPC), .iInstruction(iInstruction),
    .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget), .oValid(oValid),
    .iReady(iReady), .oInstruction(oInstruction), .oPC(oPC), .oCount(oCount)
`ifdef FETCH_REDIRECT_COUNT_EN
    , .oRedirectCount(oRedirectCount)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [ADDR_W-1:0]  mFpc;
  logic [ADDR_W-1:0]  pcQ[$];
  logic [INSTR_W-1:0] inQ[$];
  bit                 justReset;
  int                 mRed;

  task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkOutputs();
    checkValue("valid", 32'(oValid), 32'(pcQ.size() != 0));
    checkValue("count", 32'(oCount), 32'(pcQ.size()));
    checkValue("addr",  32'(oAddressPC), 32'(mFpc));
    if (pcQ.size() != 0) begin
      checkValue("headPc",    32'(oPC), 32'(pcQ[0]));
      checkValue("headInstr", 32'(oInstruction), 32'(inQ[0]));
    end else if (justReset) begin
      checkValue("rstPc",    32'(oPC), 32'h0);
      checkValue("rstInstr", 32'(oInstruction), 32'h0);
    end
`ifdef FETCH_REDIRECT_COUNT_EN
    checkValue("redirect", 32'(oRedirectCount), 32'(mRed));
`endif
  endtask

  task automatic stepModel(input bit rst, input bit br, input bit rdy, input logic [ADDR_W-1:0] tgt);
    bit doPop, doPush;
    if (rst) begin
      pcQ.delete(); inQ.delete();
      mFpc = RESET_PC; mRed = 0; justReset = 1'b1;
    end else if (br) begin
      pcQ.delete(); inQ.delete();
      mFpc = tgt;
      if (mRed < 65535) mRed++;
    end else begin
      doPop  = (pcQ.size() != 0) && rdy;
      doPush = (pcQ.size() < DEPTH) || doPop;
      if (doPop) begin
        void'(pcQ.pop_front()); void'(inQ.pop_front());
      end
      if (doPush) begin
        pcQ.push_back(mFpc); inQ.push_back(memWord(mFpc));
        mFpc = mFpc + 10'd1;
        justReset = 1'b0;
      end
    end
  endtask

  initial begin
    bit rst, br, rdy;
    logic [ADDR_W-1:0] tgt;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    pcQ.delete(); inQ.delete();
    mFpc = RESET_PC; mRed = 0; justReset = 1'b1;

    for (int cyc = 0; cyc < 400; cyc++) begin
      checkOutputs();
      rst = 1'b0; br = 1'b0; tgt = ADDR_W'($urandom_range(0, 1023));
      if (cyc < 20)       rdy = 1'b1;                          // free run
      else if (cyc < 28)  rdy = 1'b0;                          // fill and stall
      else if (cyc < 60)  rdy = 1'b1;                          // drain / full throughput
      else if (cyc < 97)  rdy = ($urandom_range(0, 3) != 0);
      else if (cyc < 100) rdy = 1'b0;
      else                rdy = ($urandom_range(0, 2) != 0);
      if (cyc == 40) begin br = 1'b1; tgt = 10'h3FD; end       // wrap through 0x3FF
      if (cyc == 52) begin br = 1'b1; tgt = 10'h120; end
      if (cyc == 100) begin rst = 1'b1; br = 1'b1; end         // reset beats redirect
      if (cyc > 100) begin
        br  = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 63) == 0);
      end
      Reset = rst; iBranchTaken = br; iReady = rdy; iBranchTarget = tgt;
      stepModel(rst, br, rdy, tgt);
      @(negedge Clock);
    end
    checkOutputs();

`ifdef FETCH_REDIRECT_COUNT_EN
    Reset = 1'b0; iBranchTaken = 1'b1;
    repeat (70000) @(negedge Clock);
    checkValue("redirectSat", 32'(oRedirectCount), 32'h0000FFFF);
    Reset = 1'b1;
    @(negedge Clock);
    checkValue("redirectClr", 32'(oRedirectCount), 32'h0);
    checkValue("rstValid", 32'(oValid), 32'h0);
    checkValue("rstAddr",  32'(oAddressPC), 32'(RESET_PC));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
